// File: rtl/map_portb_scheduler.sv
// Port B arbiter for the map/candy BRAM: full-map refill from ROM, pacman
// read/clear-write, and round-robin ghost tile reads with tagged responses.
module map_portb_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int DATA_DEPTH = 1152,
  parameter int ADDR_W     = 11
) (
  input  logic                  vga_pix_clk,
  input  logic                  rst,
  input  logic                  refill_start,
  output logic                  refill_busy,
  output logic                  refill_done,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  pac_req,
  input  logic                  pac_we,
  input  logic [ADDR_W-1:0]     pac_addr,
  input  logic [DATA_WIDTH-1:0] pac_wdata,
  output logic                  pac_gnt,
  input  logic [3:0]            ghost_req,
  input  logic [4*ADDR_W-1:0]   ghost_addr,
  output logic [3:0]            ghost_gnt,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                done_q, done_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [2:0]          rsp_id_q, rsp_id_d;
  logic                rsp_oor_q, rsp_oor_d;

  logic                sel_valid;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic [2:0]          sel_id;
  logic                found;
  logic [1:0]          idx;
  logic [1:0]          gi;
  logic                sel_in_range;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < DATA_DEPTH);
  endfunction

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    done_d       = 1'b0;
    ptr_d        = ptr_q;
    rsp_vld_d    = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_oor_d    = rsp_oor_q;
    pac_gnt      = 1'b0;
    ghost_gnt    = 4'b0000;
    bram_addr    = '0;
    bram_we      = 1'b0;
    bram_din     = '0;
    sel_valid    = 1'b0;
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_din      = '0;
    sel_id       = 3'd0;
    found        = 1'b0;
    idx          = 2'd0;
    gi           = 2'd0;
    sel_in_range = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (refill_start) begin
            state_d = REFILL;
            k_d     = '0;
          end else if (pac_req) begin
            pac_gnt   = 1'b1;
            sel_valid = 1'b1;
            sel_we    = pac_we;
            sel_addr  = pac_addr;
            sel_din   = pac_wdata;
            sel_id    = 3'd4;
          end else if (|ghost_req) begin
            // Search starts at the pointer and wraps; first requester wins.
            for (int off = 0; off < 4; off++) begin
              idx = ptr_q + 2'(off);
              if (!found && ghost_req[idx]) begin
                found = 1'b1;
                gi    = idx;
              end
            end
            ghost_gnt[gi] = 1'b1;
            sel_valid     = 1'b1;
            sel_addr      = ghost_addr[gi*ADDR_W +: ADDR_W];
            sel_id        = {1'b0, gi};
            ptr_d         = gi + 2'd1;
          end
        end
      end
      REFILL: begin
        // ROM data lags its address by one cycle, so write entry k-1.
        if (k_q != '0) begin
          bram_addr = k_q - 1'b1;
          bram_we   = 1'b1;
          bram_din  = rom_data;
        end
        if (k_q == LAST) state_d = FLUSH;
        else             k_d     = k_q + 1'b1;
      end
      FLUSH: begin
        bram_addr = LAST;
        bram_we   = 1'b1;
        bram_din  = rom_data;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sel_valid) begin
      sel_in_range = addr_in_range(sel_addr);
      bram_addr    = sel_addr;
      bram_we      = sel_we & sel_in_range;
      bram_din     = sel_din;
      if (!sel_we) begin
        rsp_vld_d = 1'b1;
        rsp_id_d  = sel_id;
        rsp_oor_d = ~sel_in_range;
      end
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      done_q    <= 1'b0;
      ptr_q     <= 2'd0;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // Response tag registers carry data only; outputs are gated by valid.
  always_ff @(posedge vga_pix_clk) begin
    rsp_id_q  <= rsp_id_d;
    rsp_oor_q <= rsp_oor_d;
  end

  assign refill_busy = (state_q != IDLE);
  assign refill_done = done_q;
  assign rom_addr    = k_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_id      = rsp_vld_q ? rsp_id_q : 3'd0;
  assign rsp_data    = (rsp_vld_q && !rsp_oor_q) ? bram_dout : '0;

endmodule

// File: tb/tb_map_portb_scheduler.sv
// Directed bench for map_portb_scheduler with behavioural BRAM port B and map ROM.
module tb_map_portb_scheduler;

  localparam int DW = 4;
  localparam int DD = 1152;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          refill_start;
  logic          refill_busy;
  logic          refill_done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          pac_req;
  logic          pac_we;
  logic [AW-1:0] pac_addr;
  logic [DW-1:0] pac_wdata;
  logic          pac_gnt;
  logic [3:0]    ghost_req;
  logic [4*AW-1:0] ghost_addr;
  logic [3:0]    ghost_gnt;
  logic          rsp_valid;
  logic [2:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  logic [DW-1:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_portb_scheduler #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_W(AW)) dut (
    .vga_pix_clk(clk), .rst(rst),
    .refill_start(refill_start), .refill_busy(refill_busy), .refill_done(refill_done),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pac_req(pac_req), .pac_we(pac_we), .pac_addr(pac_addr), .pac_wdata(pac_wdata),
    .pac_gnt(pac_gnt),
    .ghost_req(ghost_req), .ghost_addr(ghost_addr), .ghost_gnt(ghost_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 3 + 1) & 15);
  endfunction

  function automatic logic [DW-1:0] rom_val(input int a);
    return DW'((a * 5 + 2) & 15);
  endfunction

  // Read-first BRAM port B and synchronous map ROM.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
    rom_data  <= rom_val(int'(rom_addr));
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, busy_cnt, gnt_busy, done_cnt, mism;
    bit found;
    for (int a = 0; a < 2048; a++) mem[a] = init_val(a);
    rst = 1'b1; refill_start = 1'b0;
    pac_req = 1'b0; pac_we = 1'b0; pac_addr = '0; pac_wdata = '0;
    ghost_req = 4'b0; ghost_addr = '0;
    for (int i = 0; i < 4; i++) ghost_addr[i*AW +: AW] = AW'(100 + i);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", refill_busy, 0);
    check("rst_done", refill_done, 0);
    check("rst_romaddr", rom_addr, 0);
    check("rst_rspvalid", rsp_valid, 0);
    check("rst_we", bram_we, 0);
    rst = 1'b0;

    // 1: pacman read
    @(negedge clk);
    pac_req = 1'b1; pac_we = 1'b0; pac_addr = 11'd33;
    #1;
    check("t1_pgnt", pac_gnt, 1);
    check("t1_addr", bram_addr, 33);
    check("t1_we", bram_we, 0);
    @(negedge clk);
    pac_req = 1'b0;
    #1;
    check("t1_rspvalid", rsp_valid, 1);
    check("t1_rspid", rsp_id, 4);
    check("t1_rspdata", rsp_data, init_val(33));

    // 2: round-robin ghosts, full throughput
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ghost_req = 4'b1111;
      #1;
      check($sformatf("t2_gnt%0d", c), ghost_gnt, 1 << (c % 4));
      if (c > 0) begin
        check($sformatf("t2_vld%0d", c), rsp_valid, 1);
        check($sformatf("t2_id%0d", c), rsp_id, (c - 1) % 4);
        check($sformatf("t2_data%0d", c), rsp_data, init_val(100 + (c - 1) % 4));
      end
    end
    @(negedge clk);
    ghost_req = 4'b0;
    #1;
    check("t2_lastid", rsp_id, 3);
    check("t2_lastdata", rsp_data, init_val(103));

    // 3: pacman clear-write beats ghost read; ghost then reads cleared tile
    @(negedge clk);
    pac_req = 1'b1; pac_we = 1'b1; pac_addr = 11'd40; pac_wdata = 4'd0;
    ghost_req = 4'b0010; ghost_addr[1*AW +: AW] = 11'd40;
    #1;
    check("t3_pgnt", pac_gnt, 1);
    check("t3_we", bram_we, 1);
    check("t3_addr", bram_addr, 40);
    check("t3_ggnt0", ghost_gnt, 0);
    @(negedge clk);
    pac_req = 1'b0; pac_we = 1'b0;
    #1;
    check("t3_ggnt1", ghost_gnt, 4'b0010);
    check("t3_wr_norsp", rsp_valid, 0);
    @(negedge clk);
    ghost_req = 4'b0;
    #1;
    check("t3_rspvalid", rsp_valid, 1);
    check("t3_rspid", rsp_id, 1);
    check("t3_rspdata", rsp_data, 0);
    @(negedge clk);
    pac_req = 1'b1; pac_we = 1'b1; pac_addr = 11'd41; pac_wdata = 4'd5;
    #1;
    check("t3_w41gnt", pac_gnt, 1);
    @(negedge clk);
    pac_we = 1'b0;
    #1;
    check("t3_r41gnt", pac_gnt, 1);
    @(negedge clk);
    pac_req = 1'b0;
    #1;
    check("t3_r41data", rsp_data, 5);

    // 4: full refill with a pacman read held throughout
    @(negedge clk);
    refill_start = 1'b1; pac_req = 1'b1; pac_we = 1'b0; pac_addr = 11'd10;
    #1;
    check("t4_start_pgnt", pac_gnt, 0);
    done_at = 0; busy_cnt = 0; gnt_busy = 0;
    for (int n = 1; n <= 1300 && done_at == 0; n++) begin
      @(negedge clk);
      refill_start = 1'b0;
      #1;
      if (refill_busy) busy_cnt++;
      if (refill_busy && (pac_gnt || ghost_gnt != 4'b0)) gnt_busy++;
      if (refill_done) done_at = n;
    end
    check("t4_done_at", done_at, 1154);
    check("t4_busy_cycles", busy_cnt, 1153);
    check("t4_gnt_while_busy", gnt_busy, 0);
    check("t4_pgnt_after", pac_gnt, 1);
    @(negedge clk);
    pac_req = 1'b0;
    #1;
    check("t4_done_pulse", refill_done, 0);
    check("t4_rspid", rsp_id, 4);
    check("t4_rspdata", rsp_data, rom_val(10));
    mism = 0;
    for (int a = 0; a < DD; a++) if (mem[a] !== rom_val(a)) mism++;
    check("t4_image", mism, 0);

    // 5: reset in the middle of a refill
    @(negedge clk);
    refill_start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      refill_start = 1'b0;
      #1;
      if (refill_busy && rom_addr == 11'd500) found = 1'b1;
    end
    check("t5_reach500", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_busy", refill_busy, 0);
    check("t5_done", refill_done, 0);
    check("t5_romaddr", rom_addr, 0);
    check("t5_rspvalid", rsp_valid, 0);
    check("t5_we", bram_we, 0);
    done_cnt = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      #1;
      if (refill_done || refill_busy) done_cnt++;
    end
    check("t5_no_done", done_cnt, 0);
    @(negedge clk);
    refill_start = 1'b1;
    done_at = 0;
    for (int n = 1; n <= 1300 && done_at == 0; n++) begin
      @(negedge clk);
      refill_start = 1'b0;
      #1;
      if (refill_done) done_at = n;
    end
    check("t5_redo_done_at", done_at, 1154);

    // 6: out-of-range accesses and refill_start ignored while busy
    @(negedge clk);
    ghost_addr[3*AW +: AW] = 11'd1200; ghost_req = 4'b1000;
    #1;
    check("t6_ggnt", ghost_gnt, 4'b1000);
    check("t6_we", bram_we, 0);
    @(negedge clk);
    ghost_req = 4'b0;
    pac_req = 1'b1; pac_we = 1'b1; pac_addr = 11'd1300; pac_wdata = 4'd7;
    #1;
    check("t6_rspvalid", rsp_valid, 1);
    check("t6_rspid", rsp_id, 3);
    check("t6_rspdata", rsp_data, 0);
    check("t6_oorw_gnt", pac_gnt, 1);
    check("t6_oorw_we", bram_we, 0);
    @(negedge clk);
    pac_req = 1'b0; pac_we = 1'b0;
    refill_start = 1'b1;
    done_at = 0; done_cnt = 0;
    for (int n = 1; n <= 1400; n++) begin
      @(negedge clk);
      refill_start = (n == 10);
      #1;
      if (refill_done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
    end
    refill_start = 1'b0;
    check("t6_done_cnt", done_cnt, 1);
    check("t6_done_at", done_at, 1154);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
